ce_monitor: RTL



---
 rtl/ce_monitor_pkg.sv | 9 +
 rtl/ce_monitor_if.sv | 16 +
 rtl/ce_counter.sv | 49 ++++
 rtl/ce_monitor.sv | 75 +++++++
 4 files changed

// File: rtl/ce_monitor_pkg.sv
// ce_monitor_pkg: shared types and constants for the clock-enable monitor
package ce_monitor_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;
  localparam int CNT_W = 16;
  localparam int CE_IDX_4M = 0;
  localparam int CE_IDX_8M = 1;
  localparam int CE_IDX_16M = 2;
  localparam int CE_IDX_7M = 3;
endpackage

// File: rtl/ce_monitor_if.sv
// ce_monitor_if: strobe inputs and measurement results of the ce monitor
interface ce_monitor_if;
  import ce_monitor_pkg::*;
  logic locked, ce_4m, ce_8m, ce_16m, ce_7_16m, clr_err;
  logic [CNT_W-1:0] cnt_4m, cnt_8m, cnt_16m, cnt_7m;
  logic [3:0] freq_ok, err_width;
  logic meas_valid, meas_done, err_nest;
  modport master (
    output locked, ce_4m, ce_8m, ce_16m, ce_7_16m, clr_err,
    input  cnt_4m, cnt_8m, cnt_16m, cnt_7m, freq_ok, err_width, meas_valid, meas_done, err_nest
  );
  modport slave (
    input  locked, ce_4m, ce_8m, ce_16m, ce_7_16m, clr_err,
    output cnt_4m, cnt_8m, cnt_16m, cnt_7m, freq_ok, err_width, meas_valid, meas_done, err_nest
  );
endinterface

// File: rtl/ce_counter.sv
// ce_counter: saturating strobe counter with width check and tolerance compare
module ce_counter import ce_monitor_pkg::*; #(
  parameter int EXP = 400,
  parameter int TOL = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             active,
  input  logic             run,
  input  logic             end_win,
  input  logic             drop,
  input  logic             clr_err,
  input  logic             ce,
  output logic [CNT_W-1:0] cnt,
  output logic             ok,
  output logic             err
);
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
  logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d, fin;
  logic signed [CNT_W:0] diff;
  logic prev_q, prev_d, ok_q, ok_d, err_q, err_d;
  always_comb begin
    fin = &acc_q ? acc_q : acc_q + CNT_W'(ce);
    diff = $signed({1'b0, fin}) - EXP_S;
    acc_d = run && !end_win ? fin : '0;
    cnt_d = end_win ? fin : cnt_q;
    ok_d = drop ? 1'b0 : end_win ? (diff >= -TOL_S && diff <= TOL_S) : ok_q;
    prev_d = ce;
    err_d = (active && ce && prev_q) || (err_q && !clr_err);
  end
  always_ff @(posedge clk_sys)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ok_q <= 1'b0;
      prev_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ok_q <= ok_d;
      prev_q <= prev_d;
      err_q <= err_d;
    end
  assign cnt = cnt_q;
  assign ok = ok_q;
  assign err = err_q;
endmodule

// File: rtl/ce_monitor.sv
// ce_monitor: measures clk_gen enable strobes per window and flags rate, width and nesting faults
module ce_monitor import ce_monitor_pkg::*; #(
  parameter int WINDOW_CYCLES = 6400,
  parameter int SETTLE_CYCLES = 256,
  parameter int EXP_4M = 400,
  parameter int EXP_8M = 800,
  parameter int EXP_16M = 1600,
  parameter int EXP_7M = 716,
  parameter int TOL = 2
) (
  input logic         clk_sys,
  input logic         rst,
  ce_monitor_if.slave bus
);
  localparam int EXP_A [4] = '{EXP_4M, EXP_8M, EXP_16M, EXP_7M};
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic valid_q, valid_d, done_q, done_d, nest_q, nest_d;
  logic active, run, end_win, drop;
  logic [3:0] ce, ok, ew;
  logic [CNT_W-1:0] cnt [4];
  always_comb begin
    ce = {bus.ce_7_16m, bus.ce_16m, bus.ce_8m, bus.ce_4m};
    active = state_q != IDLE;
    drop = active && !bus.locked;
    run = state_q == MEASURE && bus.locked;
    end_win = run && tmr_q == CNT_W'(WINDOW_CYCLES - 1);
    state_d = drop ? IDLE :
              state_q == IDLE && bus.locked ? SETTLE :
              state_q == SETTLE && tmr_q == CNT_W'(SETTLE_CYCLES - 1) ? MEASURE : state_q;
    tmr_d = state_d != state_q || end_win || !active ? '0 : tmr_q + 1'b1;
    done_d = end_win;
    valid_d = drop ? 1'b0 : end_win || valid_q;
    nest_d = (active && ((ce[CE_IDX_8M] && !ce[CE_IDX_16M]) || (ce[CE_IDX_4M] && !ce[CE_IDX_8M])))
             || (nest_q && !bus.clr_err);
  end
  always_ff @(posedge clk_sys)
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      nest_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      valid_q <= valid_d;
      done_q <= done_d;
      nest_q <= nest_d;
    end
  for (genvar i = 0; i < 4; i++) begin : g_ce
    ce_counter #(.EXP(EXP_A[i]), .TOL(TOL)) u_cnt (
      .clk_sys (clk_sys),
      .rst     (rst),
      .active  (active),
      .run     (run),
      .end_win (end_win),
      .drop    (drop),
      .clr_err (bus.clr_err),
      .ce      (ce[i]),
      .cnt     (cnt[i]),
      .ok      (ok[i]),
      .err     (ew[i])
    );
  end
  assign bus.cnt_4m = cnt[CE_IDX_4M];
  assign bus.cnt_8m = cnt[CE_IDX_8M];
  assign bus.cnt_16m = cnt[CE_IDX_16M];
  assign bus.cnt_7m = cnt[CE_IDX_7M];
  assign bus.freq_ok = ok;
  assign bus.err_width = ew;
  assign bus.meas_valid = valid_q;
  assign bus.meas_done = done_q;
  assign bus.err_nest = nest_q;
endmodule
